sum_threshold_acc: RTL and testbench



---
 rtl/sum_threshold_acc_if.sv | 13 +
 rtl/sum_threshold_acc.sv | 147 ++++++++++++++
 tb/tb_sum_threshold_acc.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_threshold_acc_if.sv
// sum_threshold_acc_if: valid/ready packet streams into and out of the sum/threshold stage
interface sum_threshold_acc_if #(
   parameter int WIDTH = 35
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/sum_threshold_acc.sv
// sum_threshold_acc: gathers NUM_PE partial sums (plus a residue after timestep 0), thresholds
// the total and emits a spike/residue packet. Define LEAK_EN to subtract LEAK before thresholding.
module sum_threshold_acc #(
   parameter int                  WIDTH     = 35,
   parameter int                  DATA_W    = 8,
   parameter int                  NUM_PE    = 10,
   parameter logic [4*NUM_PE-1:0] PE_ADDRS  = 40'hEA62D951C8,
   parameter logic [3:0]          RES_ADDR  = 4'hF,
   parameter logic [3:0]          SELF_ADDR = 4'h3,
   parameter int                  THRESH    = 64,
   parameter int                  NEURONS   = 280,
   parameter int                  LEAK      = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   sum_threshold_acc_if.slave bus,
   output logic [7:0]         tstep,
   output logic [9:0]         neuron_idx,
   output logic               dup_err,
   output logic [7:0]         unk_cnt,
   output logic               sat_flag
);
   localparam int AW  = DATA_W + 4;
   localparam int PAD = WIDTH - 13 - DATA_W;
   typedef enum logic [1:0] {COLLECT, SUM, SEND} state_t;
   state_t            state;
   logic [DATA_W-1:0] vals [NUM_PE];
   logic [DATA_W-1:0] res_val;
   logic [NUM_PE-1:0] mask;
   logic [NUM_PE-1:0] hit;
   logic [NUM_PE-1:0] mask_n;
   logic              res_bit;
   logic              res_n;
   logic              is_res;
   logic              pe_hit;
   logic              accept;
   logic              dup;
   logic              done;
   logic [3:0]        src;
   logic [DATA_W-1:0] din;
   logic [AW-1:0]     sum;
   logic [AW-1:0]     sum_l;
   logic [AW-1:0]     acc;
   logic [AW-1:0]     resid;
   logic              spike;
   logic              clip;
   logic [DATA_W-1:0] res_out;
   logic [WIDTH-1:0]  pkt;
   logic              out_valid_q;
   logic [WIDTH-1:0]  out_data_q;
   logic              unused_bits;
   assign src          = bus.in_data[26:23];
   assign din          = bus.in_data[DATA_W-1:0];
   assign unused_bits  = &{1'b0, bus.in_data[WIDTH-1:27], bus.in_data[22:DATA_W]};
   assign bus.in_ready = rst_n && (state == COLLECT);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   // decode the source ID of the offered packet against the known sources and the current mask
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_PE; i++) hit[i] = (src == PE_ADDRS[4*i +: 4]);
      pe_hit = |hit;
      is_res = (src == RES_ADDR) && (tstep != 8'd0);
      accept = bus.in_valid && bus.in_ready;
      mask_n = mask | hit;
      res_n  = res_bit | is_res;
      dup    = (|(hit & mask)) || (is_res && res_bit);
      done   = (&mask_n) && (res_n || tstep == 8'd0);
   end
   // add all stored partial sums and the residue (only present from timestep 1 on), then leak
   always_comb begin
      sum = res_bit ? AW'(res_val) : '0;
      for (int i = 0; i < NUM_PE; i++) sum = sum + AW'(vals[i]);
`ifdef LEAK_EN
      sum_l = (sum > AW'(LEAK)) ? sum - AW'(LEAK) : '0;
`else
      sum_l = sum;
`endif
   end
`ifndef LEAK_EN
   logic unused_leak;
   assign unused_leak = (LEAK != 0);
`endif
   // threshold the registered sum and build the outgoing packet, clipping the residue to DATA_W bits
   always_comb begin
      spike   = (acc >= AW'(THRESH));
      resid   = spike ? acc - AW'(THRESH) : acc;
      clip    = (resid > AW'((1 << DATA_W) - 1));
      res_out = clip ? '1 : resid[DATA_W-1:0];
      pkt     = {SELF_ADDR, RES_ADDR, SELF_ADDR, spike, {PAD{1'b0}}, res_out};
   end
   // control FSM: collect packets, register the sum, present the result until it is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= COLLECT;
         for (int i = 0; i < NUM_PE; i++) vals[i] <= '0;
         res_val     <= '0;
         mask        <= '0;
         res_bit     <= 1'b0;
         acc         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         tstep       <= '0;
         neuron_idx  <= '0;
         dup_err     <= 1'b0;
         unk_cnt     <= '0;
         sat_flag    <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  for (int i = 0; i < NUM_PE; i++) if (hit[i]) vals[i] <= din;
                  if (is_res) res_val <= din;
                  if (!pe_hit && !is_res && unk_cnt != 8'hFF) unk_cnt <= unk_cnt + 8'd1;
                  if (dup) dup_err <= 1'b1;
                  mask    <= mask_n;
                  res_bit <= res_n;
                  if (done) state <= SUM;
               end
            end
            SUM: begin
               acc   <= sum_l;
               state <= SEND;
            end
            SEND: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= pkt;
                  if (clip) sat_flag <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  mask        <= '0;
                  res_bit     <= 1'b0;
                  state       <= COLLECT;
                  if (neuron_idx == 10'(NEURONS - 1)) begin
                     neuron_idx <= '0;
                     if (tstep != 8'hFF) tstep <= tstep + 8'd1;
                  end else begin
                     neuron_idx <= neuron_idx + 10'd1;
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end
endmodule

// File: tb/tb_sum_threshold_acc.sv
// tb_sum_threshold_acc: randomized self-checking bench for sum_threshold_acc against a sum/threshold model
`timescale 1ns/1ps
module tb_sum_threshold_acc;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tstep;
   logic [9:0] neuron_idx;
   logic       dup_err;
   logic [7:0] unk_cnt;
   logic       sat_flag;
   int         checks = 0;
   int         errors = 0;
   int         exp_n = 0;
   int         exp_t = 0;
   int         pe_id [10] = '{8, 12, 1, 5, 9, 13, 2, 6, 10, 14};
   always #5 clk = ~clk;
   sum_threshold_acc_if #(.WIDTH(35)) bus ();
   sum_threshold_acc dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .tstep(tstep), .neuron_idx(neuron_idx),
      .dup_err(dup_err), .unk_cnt(unk_cnt), .sat_flag(sat_flag)
   );
   function automatic logic [34:0] model(input int v [10], input int r, output bit sat);
      int s;
      int res;
      bit spk;
      s = r;
      for (int i = 0; i < 10; i++) s += v[i];
`ifdef LEAK_EN
      s = (s > 1) ? s - 1 : 0;
`endif
      spk = (s >= 64);
      res = spk ? s - 64 : s;
      sat = (res > 255);
      if (sat) res = 255;
      return {4'h3, 4'hF, 4'h3, spk, 14'b0, 8'(res)};
   endfunction
   task automatic send_pkt(input logic [3:0] id, input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = {4'($urandom), 4'h3, id, 1'b0, 14'b0, d};
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_timeout id=%h in_ready=%b required 1", id, bus.in_ready);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask
   task automatic send_set(input int v [10], input int r, input bit with_res);
      int ord [10];
      int t;
      int j;
      int rpos;
      for (int i = 0; i < 10; i++) ord[i] = i;
      for (int i = 9; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = ord[i];
         ord[i] = ord[j];
         ord[j] = t;
      end
      rpos = $urandom_range(9, 0);
      for (int i = 0; i < 10; i++) begin
         if (with_res && i == rpos) send_pkt(4'hF, 8'(r));
         send_pkt(4'(pe_id[ord[i]]), 8'(v[ord[i]]));
      end
   endtask
   task automatic recv(input logic [34:0] exp, input string name);
      int n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
         errors++;
         $display("FAIL %s out_data: got valid=%b data=%h, required valid=1 data=%h", name, bus.out_valid, bus.out_data, exp);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      exp_n++;
      if (exp_n == 280) begin
         exp_n = 0;
         if (exp_t < 255) exp_t++;
      end
      checks++;
      if (neuron_idx !== 10'(exp_n) || tstep !== 8'(exp_t) || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s counters: got idx=%0d tstep=%0d valid=%b, required idx=%0d tstep=%0d valid=0", name, neuron_idx, tstep, bus.out_valid, exp_n, exp_t);
      end
   endtask
   task automatic run_random(input bit with_res, input string name);
      int v [10];
      int r;
      bit sat;
      logic [34:0] exp;
      for (int i = 0; i < 10; i++) v[i] = $urandom_range(25, 0);
      r = with_res ? $urandom_range(25, 0) : 0;
      exp = model(v, r, sat);
      send_set(v, r, with_res);
      recv(exp, name);
   endtask
   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: got in_ready=%b out_valid=%b, required 0 0", bus.in_ready, bus.out_valid);
      end
      rst_n = 1'b1;
      exp_n = 0;
      exp_t = 0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_data !== 35'd0 || tstep !== 8'd0 || neuron_idx !== 10'd0 ||
          dup_err !== 1'b0 || unk_cnt !== 8'd0 || sat_flag !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got in_ready=%b data=%h tstep=%0d idx=%0d dup=%b unk=%0d sat=%b, required 1 0 0 0 0 0 0",
                  bus.in_ready, bus.out_data, tstep, neuron_idx, dup_err, unk_cnt, sat_flag);
      end
   endtask
   task automatic test_reset();
      apply_reset();
   endtask
   task automatic test_fire();
      int v [10];
      bit sat;
      logic [34:0] exp;
      logic [2:0] seen;
      for (int i = 0; i < 10; i++) v[i] = 7;
      exp = model(v, 0, sat);
      send_set(v, 0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         seen[k] = bus.out_valid;
      end
      checks++;
      if (seen !== 3'b100) begin
         errors++;
         $display("FAIL fire_latency: got valid per cycle=%b, required 100", seen);
      end
      checks++;
`ifdef LEAK_EN
      if (bus.out_data[22] !== 1'b1 || bus.out_data[7:0] !== 8'd5) begin
`else
      if (bus.out_data[22] !== 1'b1 || bus.out_data[7:0] !== 8'd6) begin
`endif
         errors++;
         $display("FAIL fire_fields: got spike=%b residue=%0d, required spike=1 residue=6 (5 with leak)", bus.out_data[22], bus.out_data[7:0]);
      end
      recv(exp, "fire");
      for (int k = 0; k < 5; k++) run_random(1'b0, "random_t0");
      checks++;
      if (sat_flag !== 1'b0 || dup_err !== 1'b0) begin
         errors++;
         $display("FAIL flags_quiet: got sat=%b dup=%b, required 0 0", sat_flag, dup_err);
      end
   endtask
   task automatic test_stall();
      int v [10];
      int n = 0;
      int bad = 0;
      bit sat;
      logic [34:0] exp;
      for (int i = 0; i < 10; i++) v[i] = 6;
      exp = model(v, 0, sat);
      send_set(v, 0, 1'b0);
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.in_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0 || exp[22] !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold: got %0d bad cycles data=%h in_ready=%b, required 0 bad data=%h in_ready=0", bad, bus.out_data, bus.in_ready, exp);
      end
      recv(exp, "stall");
   endtask
   task automatic test_timestep();
      int v [10];
      bit sat;
      logic [34:0] exp;
      int guard = 0;
      while (exp_n != 0 && guard < 300) begin
         run_random(1'b0, "fill_t0");
         guard++;
      end
      checks++;
      if (tstep !== 8'd1 || neuron_idx !== 10'd0) begin
         errors++;
         $display("FAIL timestep_wrap: got tstep=%0d idx=%0d, required 1 0", tstep, neuron_idx);
      end
      for (int i = 0; i < 10; i++) v[i] = 5;
      exp = model(v, 20, sat);
      send_set(v, 20, 1'b1);
      recv(exp, "residue");
      for (int k = 0; k < 3; k++) run_random(1'b1, "random_t1");
   endtask
   task automatic test_missing_residue();
      int v [10];
      int r;
      int hi = 0;
      bit sat;
      logic [34:0] exp;
      for (int i = 0; i < 10; i++) v[i] = $urandom_range(25, 0);
      r = $urandom_range(40, 0);
      exp = model(v, r, sat);
      send_set(v, r, 1'b0);
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) hi++;
      end
      checks++;
      if (hi != 0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL no_residue_wait: got %0d valid cycles in_ready=%b, required 0 and 1", hi, bus.in_ready);
      end
      send_pkt(4'hF, 8'(r));
      recv(exp, "late_residue");
   endtask
   task automatic test_dup_unknown();
      int v [10];
      bit sat;
      logic [34:0] exp;
      apply_reset();
      for (int i = 0; i < 10; i++) v[i] = 0;
      v[0] = 9;
      exp = model(v, 0, sat);
      send_pkt(4'h8, 8'd3);
      send_pkt(4'h4, 8'($urandom));
      checks++;
      if (unk_cnt !== 8'd1 || dup_err !== 1'b0) begin
         errors++;
         $display("FAIL unknown_drop: got unk=%0d dup=%b, required 1 0", unk_cnt, dup_err);
      end
      send_pkt(4'hF, 8'd50);
      send_pkt(4'h8, 8'd9);
      checks++;
      if (unk_cnt !== 8'd2 || dup_err !== 1'b1) begin
         errors++;
         $display("FAIL dup_detect: got unk=%0d dup=%b, required 2 1", unk_cnt, dup_err);
      end
      for (int i = 1; i < 10; i++) send_pkt(4'(pe_id[i]), 8'd0);
      recv(exp, "dup_sum");
   endtask
   task automatic test_saturate();
      int v [10];
      bit sat;
      logic [34:0] exp;
      for (int i = 0; i < 10; i++) v[i] = 255;
      exp = model(v, 0, sat);
      send_set(v, 0, 1'b0);
      recv(exp, "saturate");
      checks++;
      if (sat_flag !== 1'b1 || exp[7:0] !== 8'hFF || exp[22] !== 1'b1 || !sat) begin
         errors++;
         $display("FAIL saturate_flag: got sat=%b, required 1", sat_flag);
      end
   endtask
   task automatic test_reset_mid();
      int v [10];
      bit sat;
      logic [34:0] exp;
      for (int i = 0; i < 5; i++) send_pkt(4'(pe_id[i]), 8'd7);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 35'd0 || tstep !== 8'd0 ||
          neuron_idx !== 10'd0 || dup_err !== 1'b0 || unk_cnt !== 8'd0 || sat_flag !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got rdy=%b vld=%b data=%h tstep=%0d idx=%0d dup=%b unk=%0d sat=%b, required all 0",
                  bus.in_ready, bus.out_valid, bus.out_data, tstep, neuron_idx, dup_err, unk_cnt, sat_flag);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_n = 0;
      exp_t = 0;
      for (int i = 0; i < 10; i++) v[i] = 7;
      exp = model(v, 0, sat);
      send_set(v, 0, 1'b0);
      recv(exp, "after_reset");
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_fire();
      test_stall();
      test_timestep();
      test_missing_residue();
      test_dup_unknown();
      test_saturate();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
